// File: rtl/video_host_ctrl.sv
// Host-side register window for the video block: vblank/NMI status, two-write
// scroll/address latch and host VRAM accesses sequenced onto the shared cart bus.
module video_host_ctrl #(
  parameter int P_INC_LARGE = 32,
  parameter int P_VADDR_W   = 14
) (
  input  logic                 I_clock,
  input  logic                 I_reset,
  input  logic                 I_host_cs,
  input  logic [2:0]           I_host_addr,
  input  logic                 I_host_wren,
  input  logic [7:0]           I_host_data,
  output logic [7:0]           O_host_data,
  output logic                 O_host_nmi,
  output logic                 O_host_busy,
  input  logic                 I_vblank_set,
  input  logic                 I_vblank_clr,
  input  logic                 I_spr0_hit,
  input  logic                 I_spr_ovf,
  input  logic                 I_rend_req,
  input  logic [P_VADDR_W-1:0] I_rend_addr,
  output logic [7:0]           O_ctrl,
  output logic [7:0]           O_mask,
  output logic [7:0]           O_scroll_x,
  output logic [7:0]           O_scroll_y,
  output logic [7:0]           O_oam_addr,
  output logic                 O_oam_wren,
  output logic [7:0]           O_oam_data,
  output logic [P_VADDR_W-1:0] O_cart_addr,
  output logic                 O_cart_wren,
  input  logic [7:0]           I_cart_data,
  output logic [7:0]           O_cart_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic [P_VADDR_W-1:0] LP_INC_LARGE = P_VADDR_W'(P_INC_LARGE);
  localparam logic [P_VADDR_W-1:0] LP_INC_ONE   = P_VADDR_W'(1);

  // Host handshake: I_host_cs is a one-cycle strobe with no backpressure.
  // O_host_busy is advisory; DATA writes while busy are dropped and DATA
  // reads while busy return the buffer without starting a new fetch.

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_ctrl;
  logic [7:0]             r_mask;
  logic [7:0]             r_scroll_x;
  logic [7:0]             r_scroll_y;
  logic [7:0]             r_oam_addr;
  logic                   r_oam_wren;
  logic [7:0]             r_oam_data;
  logic                   r_toggle;
  logic [7:0]             r_latch;
  logic [7:0]             r_rbuf;
  logic [7:0]             r_host_data;
  logic                   r_vblank;
  logic                   r_nmi;
  logic [P_VADDR_W-1:0]   r_vaddr;
  logic [P_VADDR_W-1:0]   r_taddr;
  logic [P_VADDR_W-1:0]   r_req_addr;
  logic                   r_req_wr;
  logic [7:0]             r_req_data;

  logic                   w_rd;
  logic                   w_wr;
  logic                   w_status_rd;
  logic                   w_data_start;
  logic                   w_addr_lo_wr;
  logic                   w_complete;
  logic [7:0]             w_rd_data;
  logic [7:0]             w_ctrl_nxt;
  logic                   w_vblank_nxt;
  logic [P_VADDR_W-1:0]   w_vaddr_inc;
  logic [P_VADDR_W-1:0]   w_cart_addr;
  logic                   w_cart_wren;
  logic [7:0]             w_cart_data;

  assign w_rd         = I_host_cs & ~I_host_wren;
  assign w_wr         = I_host_cs &  I_host_wren;
  assign w_status_rd  = w_rd && (I_host_addr == 3'd2);
  assign w_data_start = I_host_cs && (I_host_addr == 3'd7) && (r_state == S_IDLE);
  assign w_addr_lo_wr = w_wr && (I_host_addr == 3'd6) && r_toggle;
  assign w_vaddr_inc  = r_req_addr + (r_ctrl[2] ? LP_INC_LARGE : LP_INC_ONE);
  assign w_ctrl_nxt   = (w_wr && (I_host_addr == 3'd0)) ? I_host_data : r_ctrl;
  // A set pulse beats both the clear pulse and a coincident STATUS read.
  assign w_vblank_nxt = I_vblank_set | (r_vblank & ~I_vblank_clr & ~w_status_rd);

  always_comb begin
    w_rd_data = r_latch;
    case (I_host_addr)
      3'd2:    w_rd_data = {r_vblank, I_spr0_hit, I_spr_ovf, r_latch[4:0]};
      3'd7:    w_rd_data = r_rbuf;
      default: w_rd_data = r_latch;
    endcase
  end

  // Sequencer next state and cart bus ownership.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_cart_addr = I_rend_addr;
    w_cart_wren = 1'b0;
    w_cart_data = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_data_start) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (!I_rend_req) begin
          w_cart_addr = r_req_addr;
          w_cart_wren = r_req_wr;
          w_cart_data = r_req_data;
          if (r_req_wr) begin
            w_state_nxt = S_IDLE;
            w_complete  = 1'b1;
          end else begin
            w_state_nxt = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_IDLE;
        w_complete  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_ctrl      <= 8'h00;
      r_mask      <= 8'h00;
      r_scroll_x  <= 8'h00;
      r_scroll_y  <= 8'h00;
      r_oam_addr  <= 8'h00;
      r_oam_wren  <= 1'b0;
      r_oam_data  <= 8'h00;
      r_toggle    <= 1'b0;
      r_latch     <= 8'h00;
      r_rbuf      <= 8'h00;
      r_host_data <= 8'h00;
      r_vblank    <= 1'b0;
      r_nmi       <= 1'b0;
      r_vaddr     <= '0;
      r_taddr     <= '0;
      r_req_addr  <= '0;
      r_req_wr    <= 1'b0;
      r_req_data  <= 8'h00;
    end else begin
      r_vblank   <= w_vblank_nxt;
      r_nmi      <= w_vblank_nxt & w_ctrl_nxt[7];
      r_ctrl     <= w_ctrl_nxt;
      r_oam_wren <= w_wr && (I_host_addr == 3'd4);

      if (w_rd) r_host_data <= w_rd_data;
      if (w_wr) r_latch     <= I_host_data;

      if (w_wr && (I_host_addr == 3'd1)) r_mask <= I_host_data;

      // The address advances the cycle after the write pulse so the pulse
      // is presented with the address it targets.
      if (w_wr && (I_host_addr == 3'd3))      r_oam_addr <= I_host_data;
      else if (r_oam_wren)                    r_oam_addr <= r_oam_addr + 8'd1;
      if (w_wr && (I_host_addr == 3'd4))      r_oam_data <= I_host_data;

      if (w_status_rd) begin
        r_toggle <= 1'b0;
      end else if (w_wr && ((I_host_addr == 3'd5) || (I_host_addr == 3'd6))) begin
        r_toggle <= ~r_toggle;
      end

      if (w_wr && (I_host_addr == 3'd5)) begin
        if (r_toggle) r_scroll_y <= I_host_data;
        else          r_scroll_x <= I_host_data;
      end

      if (w_wr && (I_host_addr == 3'd6)) begin
        if (r_toggle) r_taddr[7:0]           <= I_host_data;
        else          r_taddr[P_VADDR_W-1:8] <= I_host_data[P_VADDR_W-9:0];
      end

      // A completing ADDR write overrides the post-access increment.
      if (w_addr_lo_wr)    r_vaddr <= {r_taddr[P_VADDR_W-1:8], I_host_data};
      else if (w_complete) r_vaddr <= w_vaddr_inc;

      if (w_data_start) begin
        r_req_addr <= r_vaddr;
        r_req_wr   <= I_host_wren;
        r_req_data <= I_host_data;
      end

      if (r_state == S_CAPTURE) r_rbuf <= I_cart_data;
    end
  end

  assign O_host_data = r_host_data;
  assign O_host_nmi  = r_nmi;
  assign O_host_busy = (r_state != S_IDLE);
  assign O_ctrl      = r_ctrl;
  assign O_mask      = r_mask;
  assign O_scroll_x  = r_scroll_x;
  assign O_scroll_y  = r_scroll_y;
  assign O_oam_addr  = r_oam_addr;
  assign O_oam_wren  = r_oam_wren;
  assign O_oam_data  = r_oam_data;
  assign O_cart_addr = w_cart_addr;
  assign O_cart_wren = w_cart_wren;
  assign O_cart_data = w_cart_data;

endmodule

// File: tb/tb_video_host_ctrl.sv
// Bench for video_host_ctrl: directed scenarios plus randomized register traffic
// checked every cycle against a transaction-level reference model.
module tb_video_host_ctrl;

  logic        clk;
  logic        rst_n;
  logic        host_cs;
  logic [2:0]  host_addr;
  logic        host_wren;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_nmi;
  logic        host_busy;
  logic        vset;
  logic        vclr;
  logic        spr0;
  logic        ovf;
  logic        rend_req;
  logic [13:0] rend_addr;
  logic [7:0]  ctrl_o;
  logic [7:0]  mask_o;
  logic [7:0]  scroll_x;
  logic [7:0]  scroll_y;
  logic [7:0]  oam_addr;
  logic        oam_wren;
  logic [7:0]  oam_data;
  logic [13:0] cart_addr;
  logic        cart_wren;
  logic [7:0]  cart_rdata;
  logic [7:0]  cart_wdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];

  // Reference model state.
  int m_ctrl, m_mask, m_sx, m_sy, m_oam_addr, m_oam_data, m_latch, m_rbuf;
  int m_vaddr, m_t, m_hdata, m_req_addr, m_req_data;
  bit m_oam_wren, m_toggle, m_vblank, m_nmi, m_pending, m_capture, m_req_wr;

  video_host_ctrl #(.P_INC_LARGE(32), .P_VADDR_W(14)) dut (
    .I_clock      (clk),
    .I_reset      (rst_n),
    .I_host_cs    (host_cs),
    .I_host_addr  (host_addr),
    .I_host_wren  (host_wren),
    .I_host_data  (host_wdata),
    .O_host_data  (host_rdata),
    .O_host_nmi   (host_nmi),
    .O_host_busy  (host_busy),
    .I_vblank_set (vset),
    .I_vblank_clr (vclr),
    .I_spr0_hit   (spr0),
    .I_spr_ovf    (ovf),
    .I_rend_req   (rend_req),
    .I_rend_addr  (rend_addr),
    .O_ctrl       (ctrl_o),
    .O_mask       (mask_o),
    .O_scroll_x   (scroll_x),
    .O_scroll_y   (scroll_y),
    .O_oam_addr   (oam_addr),
    .O_oam_wren   (oam_wren),
    .O_oam_data   (oam_data),
    .O_cart_addr  (cart_addr),
    .O_cart_wren  (cart_wren),
    .I_cart_data  (cart_rdata),
    .O_cart_data  (cart_wdata)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_mask = 0; m_sx = 0; m_sy = 0; m_oam_addr = 0; m_oam_data = 0;
    m_latch = 0; m_rbuf = 0; m_vaddr = 0; m_t = 0; m_hdata = 0;
    m_req_addr = 0; m_req_data = 0;
    m_oam_wren = 0; m_toggle = 0; m_vblank = 0; m_nmi = 0;
    m_pending = 0; m_capture = 0; m_req_wr = 0;
    exp_q.delete();
  endtask

  // One clock edge of the architectural rules, applied to the pre-edge inputs.
  task automatic model_step();
    bit rd, wr, start, old_oam_wren;
    int a, d, old_vaddr, inc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rd = host_cs && !host_wren;
    wr = host_cs && host_wren;
    a  = int'(host_addr);
    d  = int'(host_wdata);
    old_vaddr    = m_vaddr;
    old_oam_wren = m_oam_wren;
    inc = ((m_ctrl / 4) % 2 == 1) ? 32 : 1;

    if (rd) begin
      if (a == 2)      m_hdata = int'(m_vblank) * 128 + int'(spr0) * 64 + int'(ovf) * 32 + m_latch % 32;
      else if (a == 7) m_hdata = m_rbuf;
      else             m_hdata = m_latch;
      exp_q.push_back(8'(m_hdata));
    end

    start = host_cs && (a == 7) && !m_pending;
    if (m_pending) begin
      if (m_capture) begin
        m_rbuf = int'(cart_rdata);
        m_pending = 0; m_capture = 0;
        m_vaddr = (m_req_addr + inc) % 16384;
      end else if (!rend_req) begin
        if (m_req_wr) begin
          m_pending = 0;
          m_vaddr = (m_req_addr + inc) % 16384;
        end else begin
          m_capture = 1;
        end
      end
    end
    if (start) begin
      m_pending = 1; m_capture = 0;
      m_req_addr = old_vaddr; m_req_wr = host_wren; m_req_data = d;
    end

    if (old_oam_wren) m_oam_addr = (m_oam_addr + 1) % 256;
    m_oam_wren = wr && (a == 4);
    if (wr) begin
      m_latch = d;
      case (a)
        0: m_ctrl = d;
        1: m_mask = d;
        3: m_oam_addr = d;
        4: m_oam_data = d;
        5: begin
          if (m_toggle) m_sy = d; else m_sx = d;
          m_toggle = !m_toggle;
        end
        6: begin
          if (m_toggle) begin
            m_t = (m_t / 256) * 256 + d;
            m_vaddr = m_t;
          end else begin
            m_t = (d % 64) * 256 + m_t % 256;
          end
          m_toggle = !m_toggle;
        end
        default: ;
      endcase
    end

    if (rd && a == 2) begin
      m_vblank = 0;
      m_toggle = 0;
    end
    if (vclr) m_vblank = 0;
    if (vset) m_vblank = 1;
    m_nmi = m_vblank && ((m_ctrl / 128) == 1);
  endtask

  task automatic check_bus();
    if (m_pending && !m_capture && !rend_req) begin
      check("cart_addr", 32'(cart_addr), 32'(m_req_addr));
      check("cart_wren", 32'(cart_wren), 32'(m_req_wr));
      if (m_req_wr) check("cart_data", 32'(cart_wdata), 32'(m_req_data));
    end else begin
      check("cart_addr_rend", 32'(cart_addr), 32'(rend_addr));
      check("cart_wren_idle", 32'(cart_wren), 32'd0);
    end
    check("busy", 32'(host_busy), 32'(m_pending));
  endtask

  task automatic check_regs();
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_data", 32'(host_rdata), 32'(e));
    end else begin
      check("rd_hold", 32'(host_rdata), 32'(m_hdata));
    end
    check("nmi", 32'(host_nmi), 32'(m_nmi));
    check("ctrl", 32'(ctrl_o), 32'(m_ctrl));
    check("mask", 32'(mask_o), 32'(m_mask));
    check("scroll_x", 32'(scroll_x), 32'(m_sx));
    check("scroll_y", 32'(scroll_y), 32'(m_sy));
    check("oam_addr", 32'(oam_addr), 32'(m_oam_addr));
    check("oam_wren", 32'(oam_wren), 32'(m_oam_wren));
    check("oam_data", 32'(oam_data), 32'(m_oam_data));
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic step();
    #1;
    check_bus();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  // Driver tasks
  task automatic host_op(input logic wren, input logic [2:0] a, input logic [7:0] d);
    host_cs = 1'b1; host_wren = wren; host_addr = a; host_wdata = d;
    step();
    host_cs = 1'b0; host_wren = 1'b0; host_addr = 3'd0; host_wdata = 8'h00;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    host_op(1'b1, a, d);
  endtask

  task automatic host_rd(input logic [2:0] a);
    host_op(1'b0, a, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, 32'(host_rdata), 32'd0);
    check({tag, "_nmi"}, 32'(host_nmi), 32'd0);
    check({tag, "_busy"}, 32'(host_busy), 32'd0);
    check({tag, "_ctrl"}, 32'(ctrl_o), 32'd0);
    check({tag, "_mask"}, 32'(mask_o), 32'd0);
    check({tag, "_scroll"}, {16'd0, scroll_x, scroll_y}, 32'd0);
    check({tag, "_oam"}, {15'd0, oam_addr, oam_wren, oam_data}, 32'd0);
    check({tag, "_cart"}, {9'd0, cart_addr, cart_wren, cart_wdata}, 32'd0);
  endtask

  task automatic do_reset();
    host_cs = 0; host_wren = 0; host_addr = 0; host_wdata = 0;
    vset = 0; vclr = 0; spr0 = 0; ovf = 0; rend_req = 0; rend_addr = 0; cart_rdata = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst");
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    host_cs = 0; host_wren = 0; host_addr = 0; host_wdata = 0;
    vset = 0; vclr = 0; spr0 = 0; ovf = 0; rend_req = 0; rend_addr = 0; cart_rdata = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Host VRAM write goes out on the first free cycle with the latched address.
    host_wr(3'd6, 8'h21);
    host_wr(3'd6, 8'h08);
    host_wr(3'd7, 8'h5A);
    #1;
    check("tp1_addr", 32'(cart_addr), 32'h2108);
    check("tp1_wren", 32'(cart_wren), 32'd1);
    check("tp1_data", 32'(cart_wdata), 32'h5A);
    step();
    host_wr(3'd7, 8'h00);
    #1;
    check("tp1_vaddr_inc", 32'(cart_addr), 32'h2109);
    step();

    // Stale-read buffer and +32 wrap across the top of the address space.
    do_reset();
    host_wr(3'd0, 8'h04);
    host_wr(3'd6, 8'h3F);
    host_wr(3'd6, 8'hF0);
    host_rd(3'd7);
    check("tp2_rd0", 32'(host_rdata), 32'h00);
    #1;
    check("tp2_addr0", 32'(cart_addr), 32'h3FF0);
    step();
    cart_rdata = 8'h11;
    step();
    cart_rdata = 8'h00;
    host_rd(3'd7);
    check("tp2_rd1", 32'(host_rdata), 32'h11);
    #1;
    check("tp2_addr1", 32'(cart_addr), 32'h0010);
    step();
    cart_rdata = 8'h22;
    step();
    cart_rdata = 8'h00;
    host_wr(3'd7, 8'h00);
    #1;
    check("tp2_addr2", 32'(cart_addr), 32'h0030);
    step();

    // Renderer holds the bus for five cycles; host write waits.
    do_reset();
    rend_req = 1'b1;
    rend_addr = 14'h1234;
    host_wr(3'd7, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("tp3_rend_addr", 32'(cart_addr), 32'h1234);
      check("tp3_busy", 32'(host_busy), 32'd1);
      step();
    end
    rend_req = 1'b0;
    #1;
    check("tp3_issue_addr", 32'(cart_addr), 32'h0000);
    check("tp3_issue_data", {23'd0, cart_wren, cart_wdata}, 32'h1A5);
    step();
    check("tp3_done", 32'(host_busy), 32'd0);

    // Vblank / NMI / STATUS read interactions.
    do_reset();
    host_wr(3'd0, 8'h80);
    vset = 1'b1;
    step();
    vset = 1'b0;
    check("tp4_nmi_on", 32'(host_nmi), 32'd1);
    host_rd(3'd2);
    check("tp4_stat1", 32'(host_rdata[7]), 32'd1);
    check("tp4_nmi_off", 32'(host_nmi), 32'd0);
    host_rd(3'd2);
    check("tp4_stat2", 32'(host_rdata[7]), 32'd0);
    vset = 1'b1;
    host_rd(3'd2);
    vset = 1'b0;
    check("tp4_race_rd", 32'(host_rdata[7]), 32'd0);
    host_rd(3'd2);
    check("tp4_race_kept", 32'(host_rdata[7]), 32'd1);

    // STATUS read resets the write toggle; open-bus read of a write-only reg.
    do_reset();
    host_wr(3'd6, 8'h12);
    host_rd(3'd2);
    host_wr(3'd6, 8'h34);
    host_wr(3'd6, 8'h56);
    host_wr(3'd7, 8'h00);
    #1;
    check("tp5_vaddr", 32'(cart_addr), 32'h3456);
    step();
    host_wr(3'd1, 8'h55);
    host_rd(3'd0);
    check("tp5_openbus", 32'(host_rdata), 32'h55);

    // Asynchronous reset while a read is in its capture cycle.
    do_reset();
    host_wr(3'd6, 8'h01);
    host_wr(3'd6, 8'h00);
    host_rd(3'd7);
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("tp6");
    step();
    rst_n = 1'b1;
    host_wr(3'd7, 8'h99);
    #1;
    check("tp6_no_inc", 32'(cart_addr), 32'h0000);
    step();

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      host_cs    = ($urandom_range(0, 99) < 40);
      host_addr  = 3'($urandom_range(0, 7));
      host_wren  = 1'($urandom_range(0, 1));
      host_wdata = 8'($urandom_range(0, 255));
      vset       = ($urandom_range(0, 99) < 4);
      vclr       = ($urandom_range(0, 99) < 4);
      spr0       = 1'($urandom_range(0, 1));
      ovf        = 1'($urandom_range(0, 1));
      rend_req   = ($urandom_range(0, 99) < 50);
      rend_addr  = 14'($urandom_range(0, 16383));
      cart_rdata = 8'($urandom_range(0, 255));
      step();
    end
    host_cs = 0; vset = 0; vclr = 0; rend_req = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
